// File: rtl/inlier_stream_writer_if.sv
// Inlier output stream: one beat carries the original point index and its xyz coordinates.
interface inlier_stream_writer_if #(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 16
);
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic [N-1:0]     out_x;
   logic [N-1:0]     out_y;
   logic [N-1:0]     out_z;

   modport master (
      output out_valid,
      output out_idx,
      output out_x,
      output out_y,
      output out_z,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_idx,
      input  out_x,
      input  out_y,
      input  out_z,
      output out_ready
   );
endinterface

// File: rtl/inlier_stream_writer.sv
// Walks the point memory in index order, drops indices listed in the ascending outlier FIFO
// and streams the surviving points through a 2-entry credit-limited output buffer.
module inlier_stream_writer #(
   parameter int unsigned N           = 16,
   parameter int unsigned IDX_W       = 16,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [IDX_W-1:0]        point_cloud_size,
   input  logic                    fifo_empty,
   input  logic [IDX_W-1:0]        outlier_pos,
   output logic                    fifo_rd,
   output logic                    mem_rd,
   output logic [IDX_W-1:0]        mem_addr,
   input  logic [N-1:0]            mem_x,
   input  logic [N-1:0]            mem_y,
   input  logic [N-1:0]            mem_z,
   inlier_stream_writer_if.master  out,
   output logic                    busy,
   output logic                    done,
   output logic [IDX_W-1:0]        inlier_count,
   output logic [IDX_W-1:0]        outlier_count
);

   // Buffered beats plus reads in flight may never exceed this.
   localparam logic [1:0] Credits = 2'(MEM_LATENCY + 1);

   typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [N-1:0]     x;
      logic [N-1:0]     y;
      logic [N-1:0]     z;
   } beat_t;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] size_q;
   logic [IDX_W-1:0] inl_q;
   logic [IDX_W-1:0] outl_q;
   logic             outl_inc;
   logic             pend_q;
   logic [IDX_W-1:0] pend_idx_q;
   beat_t            buf_q [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;

   logic             start_pass;
   logic [1:0]       occ;
   logic             credit;
   beat_t            mem_beat;
   beat_t            head;
   logic             head_valid;
   logic             fire;
   logic             push_buf;
   logic             pop_buf;

   assign start_pass = (state_q == StIdle) && start;
   assign occ        = count_q + {1'b0, pend_q};
   assign credit     = occ < Credits;
   assign mem_beat   = {pend_idx_q, mem_x, mem_y, mem_z};
   assign fire       = head_valid && out.out_ready;
   // A returning beat skips the buffer only when the buffer is empty and the sink takes it now.
   assign push_buf   = pend_q && !(fire && (count_q == 2'd0));
   assign pop_buf    = fire && (count_q != 2'd0);

   // Next-state, scan decisions and FIFO/memory strobes.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      fifo_rd  = 1'b0;
      mem_rd   = 1'b0;
      outl_inc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               idx_d   = '0;
               state_d = (point_cloud_size == '0) ? StDone : StScan;
            end
         end
         StScan: begin
            if (!fifo_empty && (outlier_pos < idx_q)) begin
               // Stale or duplicate entry: discard it without advancing.
               fifo_rd = 1'b1;
            end else if (!fifo_empty && (outlier_pos == idx_q)) begin
               fifo_rd  = 1'b1;
               outl_inc = 1'b1;
               idx_d    = idx_q + IDX_W'(1);
            end else if (credit) begin
               mem_rd = 1'b1;
               idx_d  = idx_q + IDX_W'(1);
            end
            if (idx_d == size_q) state_d = StFlush;
         end
         StFlush: begin
            if ((count_q == 2'd0) && !pend_q) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state, scan index, size latch and pass counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         size_q     <= '0;
         inl_q      <= '0;
         outl_q     <= '0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= mem_rd;
         if (mem_rd) pend_idx_q <= idx_q;
         if (start_pass) begin
            size_q <= point_cloud_size;
            inl_q  <= '0;
            outl_q <= '0;
         end else begin
            if (fire)     inl_q  <= inl_q + IDX_W'(1);
            if (outl_inc) outl_q <= outl_q + IDX_W'(1);
         end
      end
   end

   // Two-entry output buffer holding beats the sink has not yet accepted.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) buf_q[i] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_buf) begin
            buf_q[wr_ptr_q] <= mem_beat;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_buf) rd_ptr_q <= ~rd_ptr_q;
         unique case ({push_buf, pop_buf})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Head of the logical queue: oldest buffered beat, else the beat returning from memory.
   always_comb begin
      head       = '0;
      head_valid = 1'b0;
      if (count_q != 2'd0) begin
         head       = buf_q[rd_ptr_q];
         head_valid = 1'b1;
      end else if (pend_q) begin
         head       = mem_beat;
         head_valid = 1'b1;
      end
   end

   assign out.out_valid = head_valid;
   assign out.out_idx   = head.idx;
   assign out.out_x     = head.x;
   assign out.out_y     = head.y;
   assign out.out_z     = head.z;

   assign mem_addr      = idx_q;
   assign busy          = (state_q == StScan) || (state_q == StFlush);
   assign done          = (state_q == StDone);
   assign inlier_count  = inl_q;
   assign outlier_count = outl_q;

endmodule

// File: tb/tb_inlier_stream_writer.sv
// Bench for inlier_stream_writer: memory and outlier-FIFO models, scoreboard of expected beats.
module tb_inlier_stream_writer;

   typedef struct packed {
      logic [15:0] idx;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] point_cloud_size = 16'd0;
   logic        fifo_empty = 1'b1;
   logic [15:0] outlier_pos = 16'd0;
   logic        fifo_rd;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] mem_x = 16'd0;
   logic [15:0] mem_y = 16'd0;
   logic [15:0] mem_z = 16'd0;
   logic        busy;
   logic        done;
   logic [15:0] inlier_count;
   logic [15:0] outlier_count;

   inlier_stream_writer_if #(.N(16), .IDX_W(16)) sif ();

   inlier_stream_writer #(.N(16), .IDX_W(16), .MEM_LATENCY(1)) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .point_cloud_size (point_cloud_size),
      .fifo_empty       (fifo_empty),
      .outlier_pos      (outlier_pos),
      .fifo_rd          (fifo_rd),
      .mem_rd           (mem_rd),
      .mem_addr         (mem_addr),
      .mem_x            (mem_x),
      .mem_y            (mem_y),
      .mem_z            (mem_z),
      .out              (sif.master),
      .busy             (busy),
      .done             (done),
      .inlier_count     (inlier_count),
      .outlier_count    (outlier_count)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   beat_t       sb[$];
   logic [15:0] fq[$];
   logic [15:0] fq_init[$];
   int          load_seq = 0;
   int          load_seen = 0;
   bit          rdy_pat[$];
   int          n_memrd = 0;
   int          n_fiford = 0;
   int          n_done = 0;
   int          n_beats = 0;
   logic [63:0] vmask;
   logic [63:0] mmask;

   function automatic logic [15:0] mx(input logic [15:0] a);
      return a * 16'd7 + 16'h0100;
   endfunction
   function automatic logic [15:0] my(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction
   function automatic logic [15:0] mz(input logic [15:0] a);
      return 16'hFFFF - a * 16'd3;
   endfunction

   // Point memory, one cycle read latency; data holds until the next read.
   always @(posedge clock) begin
      if (mem_rd) begin
         mem_x <= mx(mem_addr);
         mem_y <= my(mem_addr);
         mem_z <= mz(mem_addr);
      end
   end

   // First-word-fall-through outlier FIFO, reloaded whenever load_seq moves.
   always @(posedge clock) begin
      if (load_seq != load_seen) begin
         load_seen = load_seq;
         fq = fq_init;
      end else if (fifo_rd && fq.size() > 0) begin
         void'(fq.pop_front());
      end
      fifo_empty  <= (fq.size() == 0);
      outlier_pos <= (fq.size() > 0) ? fq[0] : 16'd0;
   end

   // Scoreboard monitor: beat order/content, stall stability, credit limit, event tallies.
   initial begin : monitor
      int    occ;
      bit    hold_v;
      beat_t held;
      beat_t got;
      beat_t exp;
      occ    = 0;
      hold_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge clock);
         got = {sif.out_idx, sif.out_x, sif.out_y, sif.out_z};
         if (!reset) begin
            sb.delete();
            occ    = 0;
            hold_v = 1'b0;
         end else begin
            if (mem_rd)   n_memrd++;
            if (fifo_rd)  n_fiford++;
            if (done)     n_done++;
            if (mem_rd) begin
               checks++;
               if (occ + 1 > 2) begin
                  errors++;
                  $display("FAIL credit_limit: outstanding %0d, allowed 2", occ + 1);
               end
            end
            if (hold_v) begin
               checks++;
               if (sif.out_valid !== 1'b1 || got !== held) begin
                  errors++;
                  $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                           sif.out_valid, got, held);
               end
            end
            if (sif.out_valid && sif.out_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got %h, required none", got);
               end else begin
                  exp = sb.pop_front();
                  if (got !== exp) begin
                     errors++;
                     $display("FAIL beat: got %h, required %h", got, exp);
                  end
               end
               n_beats++;
            end
            occ    = occ + int'(mem_rd) - int'(sif.out_valid && sif.out_ready);
            hold_v = sif.out_valid && !sif.out_ready;
            held   = got;
         end
      end
   end

   // Loads the FIFO, pushes expected beats, pulses start and runs until done or budget.
   task automatic run_pass(input logic [15:0] size, input int budget, output int done_cyc);
      for (int i = 0; i < int'(size); i++) begin
         bit skip = 1'b0;
         foreach (fq_init[j]) if (fq_init[j] == 16'(i)) skip = 1'b1;
         if (!skip) sb.push_back({16'(i), mx(16'(i)), my(16'(i)), mz(16'(i))});
      end
      load_seq++;
      @(posedge clock); #1;
      point_cloud_size = size;
      start    = 1'b1;
      vmask    = '0;
      mmask    = '0;
      done_cyc = -1;
      for (int c = 1; c <= budget && done_cyc < 0; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
         sif.out_ready = (rdy_pat.size() > 0) ? rdy_pat[(c - 1) % rdy_pat.size()] : 1'b1;
         if (c < 64 && sif.out_valid) vmask[c] = 1'b1;
         if (c < 64 && mem_rd)        mmask[c] = 1'b1;
         if (done) done_cyc = c;
      end
      @(posedge clock); #1;
      sif.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      @(posedge clock); @(posedge clock); #1;
      checks++;
      if ({fifo_rd, mem_rd, sif.out_valid, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b, required 00000",
                  {fifo_rd, mem_rd, sif.out_valid, busy, done});
      end
      checks++;
      if ({inlier_count, outlier_count, sif.out_idx, mem_addr} !== 64'd0) begin
         errors++;
         $display("FAIL reset_values: got %h, required 0",
                  {inlier_count, outlier_count, sif.out_idx, mem_addr});
      end
      @(negedge clock); #2;
      reset = 1'b1;
   endtask

   task automatic test_basic();
      int dc, b_beats, b_frd, b_done;
      b_beats = n_beats; b_frd = n_fiford; b_done = n_done;
      fq_init = '{16'd2, 16'd5};
      run_pass(16'd8, 100, dc);
      checks++;
      if (dc < 0) begin errors++; $display("FAIL basic_done_timeout: got none, required done"); end
      checks++;
      if (n_beats - b_beats != 6) begin
         errors++; $display("FAIL basic_beats: got %0d, required 6", n_beats - b_beats);
      end
      checks++;
      if (n_fiford - b_frd != 2) begin
         errors++; $display("FAIL basic_fifo_rd: got %0d, required 2", n_fiford - b_frd);
      end
      checks++;
      if (inlier_count !== 16'd6 || outlier_count !== 16'd2) begin
         errors++;
         $display("FAIL basic_counts: got %0d/%0d, required 6/2", inlier_count, outlier_count);
      end
      checks++;
      if (n_done - b_done != 1) begin
         errors++; $display("FAIL basic_done_pulses: got %0d, required 1", n_done - b_done);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_timing();
      int dc, b_frd;
      b_frd = n_fiford;
      fq_init = {};
      run_pass(16'd4, 100, dc);
      checks++;
      if (vmask[7:0] !== 8'h3C) begin
         errors++; $display("FAIL timing_valid: got %b, required 00111100", vmask[7:0]);
      end
      checks++;
      if (mmask[7:0] !== 8'h1E) begin
         errors++; $display("FAIL timing_mem_rd: got %b, required 00011110", mmask[7:0]);
      end
      checks++;
      if (dc != 7) begin errors++; $display("FAIL timing_done: got cycle %0d, required 7", dc); end
      checks++;
      if (n_fiford != b_frd) begin
         errors++; $display("FAIL timing_fifo_rd: got %0d, required 0", n_fiford - b_frd);
      end
   endtask

   task automatic test_backpressure();
      int dc, b_beats;
      b_beats = n_beats;
      fq_init = {};
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      run_pass(16'd6, 200, dc);
      rdy_pat = {};
      checks++;
      if (dc < 0) begin errors++; $display("FAIL bp_done_timeout: got none, required done"); end
      checks++;
      if (n_beats - b_beats != 6 || inlier_count !== 16'd6) begin
         errors++;
         $display("FAIL bp_beats: got %0d/%0d, required 6/6", n_beats - b_beats, inlier_count);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_all_outliers();
      int dc, b_mrd, b_frd;
      b_mrd = n_memrd; b_frd = n_fiford;
      fq_init = '{16'd0, 16'd1, 16'd2};
      run_pass(16'd3, 100, dc);
      checks++;
      if (dc != 5) begin errors++; $display("FAIL allout_done: got cycle %0d, required 5", dc); end
      checks++;
      if (n_memrd != b_mrd || vmask !== 64'd0) begin
         errors++;
         $display("FAIL allout_no_read: got mem_rd %0d valid %h, required 0 0",
                  n_memrd - b_mrd, vmask);
      end
      checks++;
      if (outlier_count !== 16'd3 || inlier_count !== 16'd0 || n_fiford - b_frd != 3) begin
         errors++;
         $display("FAIL allout_counts: got out=%0d in=%0d pops=%0d, required 3 0 3",
                  outlier_count, inlier_count, n_fiford - b_frd);
      end
   endtask

   task automatic test_duplicates();
      int dc, b_frd, b_beats;
      b_frd = n_fiford; b_beats = n_beats;
      fq_init = '{16'd1, 16'd1, 16'd3};
      run_pass(16'd5, 100, dc);
      checks++;
      if (outlier_count !== 16'd2 || inlier_count !== 16'd3) begin
         errors++;
         $display("FAIL dup_counts: got %0d/%0d, required 3/2", inlier_count, outlier_count);
      end
      checks++;
      if (n_fiford - b_frd != 3 || n_beats - b_beats != 3) begin
         errors++;
         $display("FAIL dup_pops_beats: got %0d/%0d, required 3/3", n_fiford - b_frd,
                  n_beats - b_beats);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL dup_drain: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_size_zero();
      int dc, b_mrd, b_beats;
      b_mrd = n_memrd; b_beats = n_beats;
      fq_init = {};
      run_pass(16'd0, 20, dc);
      checks++;
      if (dc != 1) begin errors++; $display("FAIL zero_done: got cycle %0d, required 1", dc); end
      checks++;
      if (n_memrd != b_mrd || n_beats != b_beats) begin
         errors++;
         $display("FAIL zero_activity: got mem_rd %0d beats %0d, required 0 0",
                  n_memrd - b_mrd, n_beats - b_beats);
      end
      checks++;
      if (inlier_count !== 16'd0 || outlier_count !== 16'd0) begin
         errors++;
         $display("FAIL zero_counts: got %0d/%0d, required 0/0", inlier_count, outlier_count);
      end
   endtask

   task automatic test_reset_mid_pass();
      int dc, b_beats, b_mrd, b_frd;
      bit seen;
      fq_init = '{16'd6};
      for (int i = 0; i < 8; i++)
         if (i != 6) sb.push_back({16'(i), mx(16'(i)), my(16'(i)), mz(16'(i))});
      b_beats = n_beats;
      load_seq++;
      @(posedge clock); #1;
      point_cloud_size = 16'd8;
      start = 1'b1;
      seen  = 1'b0;
      for (int c = 1; c <= 30 && !seen; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (n_beats - b_beats >= 2) seen = 1'b1;
      end
      checks++;
      if (!seen || busy !== 1'b1) begin
         errors++; $display("FAIL rst_mid_setup: got beats %0d busy %b, required 2 1",
                            n_beats - b_beats, busy);
      end
      @(negedge clock); #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({fifo_rd, mem_rd, sif.out_valid, busy, done} !== 5'b0 ||
          {inlier_count, outlier_count, sif.out_idx, mem_addr} !== 64'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %b %h, required 0 0",
                  {fifo_rd, mem_rd, sif.out_valid, busy, done},
                  {inlier_count, outlier_count, sif.out_idx, mem_addr});
      end
      @(negedge clock); @(negedge clock); #2;
      reset = 1'b1;
      b_mrd = n_memrd; b_frd = n_fiford;
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (n_memrd != b_mrd || n_fiford != b_frd || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_quiet: got mem_rd %0d fifo_rd %0d busy %b, required 0 0 0",
                  n_memrd - b_mrd, n_fiford - b_frd, busy);
      end
      b_beats = n_beats;
      fq_init = '{16'd4};
      run_pass(16'd8, 100, dc);
      checks++;
      if (dc < 0 || inlier_count !== 16'd7 || outlier_count !== 16'd1 ||
          n_beats - b_beats != 7) begin
         errors++;
         $display("FAIL rst_mid_rerun: got done %0d in %0d out %0d beats %0d, required >0 7 1 7",
                  dc, inlier_count, outlier_count, n_beats - b_beats);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL rst_mid_drain: got %0d left, required 0", sb.size()); end
   endtask

   initial begin
      sif.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_timing();
      test_backpressure();
      test_all_outliers();
      test_duplicates();
      test_size_zero();
      test_reset_mid_pass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
